// File: rtl/cim_wb_cmd_sequencer_pkg.sv
// Shared types and constants for the CIM Wishbone command sequencer.
package cim_wb_cmd_sequencer_pkg;

    // Sequencer FSM states; encodings are fixed so they stay stable across tools.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StPush = 2'd2
    } seq_state_e;

    // Width of one response FIFO entry: {we, err, data[31:0]}.
    localparam int unsigned RspWidth = 34;

    // Read data returned when the macro never acknowledges.
    localparam logic [31:0] ErrPatternDefault = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] data;
    } rsp_entry_t;

    // Increment an 8-bit counter, holding at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/cim_wb_cmd_sequencer_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding sequencer responses.
module cim_wb_cmd_sequencer_rsp_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned    AddrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(DEPTH);
    localparam logic [AddrW:0] CntOne   = (AddrW + 1)'(1);
    localparam logic [AddrW-1:0] PtrOne = AddrW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head is forced to zero when empty so unwritten storage never leaks out.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because the head is gated by empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cim_wb_cmd_sequencer.sv
// Wishbone classic-cycle master that turns a command stream into single
// transactions towards the CIM macro, with ack timeout and a response FIFO.
module cim_wb_cmd_sequencer
    import cim_wb_cmd_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned RSP_DEPTH      = 4,
    parameter logic [31:0] ERR_PATTERN    = ErrPatternDefault
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_we,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYCLES - 1);

    seq_state_e  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] cap_dat_q, cap_dat_d;
    logic        cap_err_q, cap_err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        fifo_push;
    logic        fifo_full;
    logic        fifo_empty;
    rsp_entry_t  fifo_wdata;
    rsp_entry_t  fifo_rdata;

    // State register plus all registered bus outputs and captured response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            cap_dat_q   <= '0;
            cap_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            cap_dat_q   <= cap_dat_d;
            cap_err_q   <= cap_err_d;
            err_count_q <= err_count_d;
        end
    end

    // Next-state logic: accept, run the bus cycle with timeout, then enqueue the response.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        cap_dat_d   = cap_dat_q;
        cap_err_d   = cap_err_q;
        err_count_d = err_count_q;
        fifo_push   = 1'b0;
        cmd_ready   = 1'b0;

        case (state_q)
            StIdle: begin
                // Only accept when a response slot is guaranteed for this command.
                cmd_ready = !fifo_full;
                if (cmd_valid && !fifo_full) begin
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    wdat_d  = cmd_dat;
                    timer_d = '0;
                    cyc_d   = 1'b1;
                    state_d = StBus;
                end
            end
            StBus: begin
                timer_d = timer_q + 16'd1;
                // Ack is checked first so it wins over a same-cycle timeout.
                if (m_ack_i) begin
                    cap_dat_d = we_q ? 32'd0 : m_dat_i;
                    cap_err_d = 1'b0;
                    cyc_d     = 1'b0;
                    state_d   = StPush;
                end else if (timer_q == TimerLast) begin
                    cap_dat_d   = ERR_PATTERN;
                    cap_err_d   = 1'b1;
                    cyc_d       = 1'b0;
                    err_count_d = sat_inc8(err_count_q);
                    state_d     = StPush;
                end
            end
            StPush: begin
                fifo_push = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign fifo_wdata = '{we: we_q, err: cap_err_q, data: cap_dat_q};

    cim_wb_cmd_sequencer_rsp_fifo #(
        .WIDTH (RspWidth),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (rsp_ready),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_dat   = fifo_rdata.data;
    assign rsp_err   = fifo_rdata.err;
    assign rsp_we    = fifo_rdata.we;

    assign m_cyc_o   = cyc_q;
    assign m_stb_o   = cyc_q;
    assign m_we_o    = we_q;
    assign m_sel_o   = sel_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = wdat_q;

    assign err_count = err_count_q;
    assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule
